mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.
//  Turns the EX/MEM load/store controls into a req/ack handshake with a data memory
//  that has variable wait states, then aligns and extends the load data for MEM/WB.
//  Raises stall, which drives the pipeline register write enables, while an access is in flight.
//  Bit order is big-endian: bit 0 is MSB; byte lane 0 is data[0:7].
// PARAMETERS
//  TIMEOUT  255  max cycles in REQ waiting for dmem_ack before a bus fault
//  TO_W     8    width of timeout counter; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous reset, active-low
//  mem_read    in   1     load in MEM stage (from EX/MEM)
//  mem_write   in   1     store in MEM stage
//  size        in   [0:1] 00 byte, 01 half, 10 word, 11 reserved
//  sign_ext    in   1     1 = sign-extend load, 0 = zero-extend
//  addr        in   [0:31] byte address (execution result)
//  store_data  in   [0:31] store value, right-justified in bits [24:31]/[16:31]
//  dmem_req    out  1     memory request, registered
//  dmem_we     out  1     1 = write, registered
//  dmem_addr   out  [0:29] word address = addr[0:29], registered
//  dmem_be     out  [0:3] byte enables, be[k] covers data[8k:8k+7], registered
//  dmem_wdata  out  [0:31] lane-replicated store data, registered
//  dmem_ack    in   1     memory done; read data valid in the same cycle
//  dmem_rdata  in   [0:31] read word
//  data_read   out  [0:31] aligned/extended load result, registered (to MEM/WB data_read_in)
//  stall       out  1     combinational; 1 freezes IF..EX/MEM
//  fault       out  1     one-cycle pulse: misaligned/illegal access or timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; dmem_req, dmem_we, stall, fault = 0;
//   dmem_addr, dmem_be, dmem_wdata, data_read = 0; timeout counter = 0.
//   Reset during REQ drops dmem_req immediately and abandons the transaction.
//  access = mem_read|mem_write. illegal = (mem_read&mem_write) | size==11 |
//   (size==01 & addr[31]) | (size==10 & addr[30:31]!=0).
//  FSM:
//   IDLE: access&!illegal -> REQ, with stall=1 this cycle; dmem_* outputs latch at the edge.
//         access&illegal -> stay IDLE; no request; stall=0; fault=1 for 1 cycle;
//           data_read <= 0 at the edge.
//         Otherwise stay IDLE with stall=0.
//   REQ:  dmem_req=1 and stall=1. Outputs are held stable until ack.
//         dmem_ack -> DONE; a read captures the aligned result into data_read.
//         Timeout count reaches TIMEOUT with no ack -> DONE; fault=1 in DONE;
//           data_read <= 0.
//   DONE: dmem_req=0 and stall=0, so the pipeline advances at this edge.
//         Always returns to IDLE. Never launches a request, even though access is still high.
//  Minimum latency: ack on the first REQ cycle gives stall for 2 cycles; data_read is valid in DONE.
//  Read align: byte lane = addr[30:31]; half lane = addr[30]; word = rdata unchanged.
//   The selected field goes right-justified into data_read[24:31] or [16:31].
//   Upper bits = sign_ext ? field MSB : 0.
//  Store: byte -> be one-hot at lane addr[30:31], wdata = {4{store_data[24:31]}}.
//   Half -> be 1100 or 0011 by addr[30], wdata = {2{store_data[16:31]}}.
//   Word -> be 1111, wdata = store_data.
//  Reads drive be=1111. Stores leave data_read unchanged.
//  dmem_ack in IDLE or DONE is ignored. The timeout counter clears on entry to REQ.
// TESTING
//  1 LW addr=0x100, ack after 3 wait cycles, rdata=0xDEADBEEF -> req 4 cycles,
//    stall 5 cycles, data_read=0xDEADBEEF, dmem_addr=0x40.
//  2 LB sign addr=0x103, rdata=0x112233F0 -> data_read=0xFFFFFFF0;
//    LBU -> 0x000000F0; LH addr=0x102 -> 0x000033F0.
//  3 SB addr=0x201, store_data=0x000000AB -> be=0100, wdata=0xABABABAB, we=1;
//    SH addr=0x202 -> be=0011.
//  4 LW addr=0x102 -> no dmem_req, fault=1 for 1 cycle, stall=0, data_read=0;
//    mem_read&mem_write -> same response.
//  5 TIMEOUT=4, no ack -> req for 4 cycles, then DONE with fault=1, data_read=0, back to IDLE.
//  6 rst low during REQ -> dmem_req=0 and stall=0 immediately;
//    after release, a new LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into a req/ack data-memory
// access and returns aligned, extended load data. Big-endian bit order (bit 0 is the MSB).
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [0:1]  size,
  input  logic        sign_ext,
  input  logic [0:31] addr,
  input  logic [0:31] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [0:29] dmem_addr,
  output logic [0:3]  dmem_be,
  output logic [0:31] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [0:31] dmem_rdata,
  output logic [0:31] data_read,
  output logic        stall,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_nx;
  logic            access, illegal, to_hit;
  logic            launch, bad, finish_ok, finish_to, stall_c;
  logic [TO_W-1:0] to_cnt;
  logic [0:1]      size_q, lane_q;
  logic            sign_q, rd_q;

  function automatic logic [0:31] align_load(input logic [0:31] w, input logic [0:1] sz,
                                             input logic [0:1] lane, input logic sx);
    logic [0:7]  b;
    logic [0:15] h;
    logic [0:31] r;
    case (lane)
      2'd0:    b = w[0:7];
      2'd1:    b = w[8:15];
      2'd2:    b = w[16:23];
      default: b = w[24:31];
    endcase
    h = lane[0] ? w[16:31] : w[0:15];
    case (sz)
      2'b00:   r = {{24{sx & b[0]}}, b};
      2'b01:   r = {{16{sx & h[0]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [0:3] store_be(input logic [0:1] sz, input logic [0:1] lane);
    logic [0:3] be;
    case (sz)
      2'b00: begin
        case (lane)
          2'd0:    be = 4'b1000;
          2'd1:    be = 4'b0100;
          2'd2:    be = 4'b0010;
          default: be = 4'b0001;
        endcase
      end
      2'b01:   be = lane[0] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [0:31] store_wdata(input logic [0:1] sz, input logic [0:31] sd);
    logic [0:31] wd;
    case (sz)
      2'b00:   wd = {4{sd[24:31]}};
      2'b01:   wd = {2{sd[16:31]}};
      default: wd = sd;
    endcase
    return wd;
  endfunction

  assign access  = mem_read | mem_write;
  assign illegal = (mem_read & mem_write) | (size == 2'b11) |
                   ((size == 2'b01) & addr[31]) |
                   ((size == 2'b10) & (addr[30:31] != 2'b00));
  assign to_hit  = (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    launch    = 1'b0;
    bad       = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            bad = 1'b1;
          end else begin
            launch   = 1'b1;
            stall_c  = 1'b1;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (dmem_ack) begin
          finish_ok = 1'b1;
          state_nx  = DONE;
        end else if (to_hit) begin
          finish_to = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Gate with reset so an access still held by the frozen pipeline cannot stall during reset
  assign stall = stall_c & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      data_read  <= '0;
      fault      <= 1'b0;
      to_cnt     <= '0;
      size_q     <= '0;
      lane_q     <= '0;
      sign_q     <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      fault <= bad | finish_to;
      if (launch) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_write;
        dmem_addr  <= addr[0:29];
        dmem_be    <= mem_write ? store_be(size, addr[30:31]) : 4'b1111;
        dmem_wdata <= store_wdata(size, store_data);
        size_q     <= size;
        lane_q     <= addr[30:31];
        sign_q     <= sign_ext;
        rd_q       <= mem_read;
        to_cnt     <= '0;
      end else if (state == REQ) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (finish_ok | finish_to) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
      end
      // Load size/lane/sign are taken from the launch snapshot, not the live EX/MEM inputs
      if (bad | finish_to)
        data_read <= '0;
      else if (finish_ok & rd_q)
        data_read <= align_load(dmem_rdata, size_q, lane_q, sign_q);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: each access pushes its expected outcome and the
// outcome observed when the access retires is popped and compared.
module tb_mem_access_unit;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, store_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata, data_read;
  logic        stall, fault;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_dr = 32'h0;

  typedef struct {
    string       tag;
    logic        illegal;
    logic        rd;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] dr;
    logic        fault;
    int          nreq;
    int          nstall;
  } exp_t;

  exp_t exp_q[$];

  mem_access_unit #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext), .addr(addr), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .data_read(data_read), .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model in little-endian numbering: byte lane k of a word is bits [31-8k -: 8].
  function automatic exp_t model(input string tag, input logic rd, input logic wr,
                                 input logic [1:0] sz, input logic sx, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rw, input int waits,
                                 input logic [31:0] prev_dr);
    exp_t e;
    logic [31:0] f;
    e.tag     = tag;
    e.rd      = rd;
    e.we      = wr;
    e.addr    = a[31:2];
    e.illegal = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                (sz == 2'b10 && a[1:0] != 2'b00);
    e.be      = 4'hF;
    e.wdata   = sd;
    if (wr && sz == 2'b00) begin
      e.be    = 4'b1000 >> a[1:0];
      e.wdata = {4{sd[7:0]}};
    end else if (wr && sz == 2'b01) begin
      e.be    = a[1] ? 4'b0011 : 4'b1100;
      e.wdata = {2{sd[15:0]}};
    end
    if (sz == 2'b00) begin
      f = (rw >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
      if (sx && f[7]) f = f | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      f = (rw >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
      if (sx && f[15]) f = f | 32'hFFFF_0000;
    end else begin
      f = rw;
    end
    if (e.illegal) begin
      e.dr = 32'h0; e.fault = 1'b1; e.nreq = 0; e.nstall = 0;
    end else if (waits < 0) begin
      e.dr = 32'h0; e.fault = 1'b1; e.nreq = TIMEOUT; e.nstall = TIMEOUT + 1;
    end else begin
      e.dr = rd ? f : prev_dr; e.fault = 1'b0; e.nreq = waits + 1; e.nstall = waits + 2;
    end
    return e;
  endfunction

  // Called at a falling edge; waits < 0 means the memory never acknowledges.
  task automatic do_txn(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rw, input int waits);
    exp_t e;
    int nreq = 0, nstall = 0, cyc = 0;
    logic done = 1'b0;
    logic [29:0] s_addr = '0;
    logic [3:0]  s_be = '0;
    logic [31:0] s_wdata = '0;
    logic        s_we = 1'b0;
    logic [31:0] o_dr;
    logic        o_fault, a_fault, a_req;

    exp_q.push_back(model(tag, rd, wr, sz, sx, a, sd, rw, waits, model_dr));
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sx; addr = a; store_data = sd;
    while (!done && cyc < 64) begin
      #1;
      if (dmem_req) begin
        if (nreq == 0) begin
          s_addr = dmem_addr; s_be = dmem_be; s_wdata = dmem_wdata; s_we = dmem_we;
        end
        nreq++;
        dmem_ack   = (waits >= 0) && (nreq == waits + 1);
        dmem_rdata = dmem_ack ? rw : 32'h5A5A_A5A5;
      end else begin
        dmem_ack = 1'b0;
      end
      if (stall) nstall++;
      else       done = 1'b1;
      if (!done) begin
        @(posedge clk); @(negedge clk); cyc++;
      end
    end
    dmem_ack = 1'b0;
    e = exp_q.pop_front();
    chk({e.tag, "_retire"}, 32'(done), 32'd1);
    if (e.illegal) begin
      @(posedge clk); @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      o_dr = data_read; o_fault = fault;
    end else begin
      // access stays high through DONE; the unit must not relaunch
      o_dr = data_read; o_fault = fault;
      @(posedge clk); @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
    end
    if (e.illegal) begin
      @(posedge clk); @(negedge clk); #1;
    end
    a_fault = fault; a_req = dmem_req;
    chk({e.tag, "_nreq"},   32'(nreq),   32'(e.nreq));
    chk({e.tag, "_nstall"}, 32'(nstall), 32'(e.nstall));
    chk({e.tag, "_fault"},  32'(o_fault), 32'(e.fault));
    chk({e.tag, "_dr"},     o_dr, e.dr);
    chk({e.tag, "_fault_after"}, 32'(a_fault), 32'd0);
    chk({e.tag, "_req_after"},   32'(a_req),   32'd0);
    if (!e.illegal) begin
      chk({e.tag, "_addr"}, 32'(s_addr), 32'(e.addr));
      chk({e.tag, "_be"},   32'(s_be),   32'(e.be));
      chk({e.tag, "_we"},   32'(s_we),   32'(e.we));
      if (e.we) chk({e.tag, "_wdata"}, s_wdata, e.wdata);
    end
    model_dr = e.dr;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_addr", 32'(dmem_addr), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_dr", data_read, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    do_txn("lw_wait3", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
    do_txn("lb_sign",  1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h1122_33F0, 0);
    do_txn("lbu",      1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h1122_33F0, 1);
    do_txn("lh_102",   1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h1122_33F0, 0);
    do_txn("lh_neg",   1, 0, 2'b01, 1, 32'h100, 32'h0, 32'h8001_0000, 2);
    do_txn("lb_lane1", 1, 0, 2'b00, 1, 32'h101, 32'h0, 32'h0080_0000, 0);
    do_txn("sb_201",   0, 1, 2'b00, 0, 32'h201, 32'h0000_00AB, 32'h0, 1);
    do_txn("sh_202",   0, 1, 2'b01, 0, 32'h202, 32'h0000_1234, 32'h0, 0);
    do_txn("sh_200",   0, 1, 2'b01, 0, 32'h200, 32'hFFFF_5678, 32'h0, 0);
    do_txn("sw_204",   0, 1, 2'b10, 0, 32'h204, 32'hCAFE_F00D, 32'h0, 2);

    // asynchronous reset while a load is waiting in REQ
    mem_read = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h300;
    @(posedge clk); @(negedge clk); #1;
    chk("rstreq_pre_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rstreq_req", 32'(dmem_req), 32'd0);
    chk("rstreq_stall", 32'(stall), 32'd0);
    chk("rstreq_dr", data_read, 32'd0);
    model_dr = 32'h0;
    @(negedge clk); mem_read = 1'b0; rst = 1'b1;
    @(negedge clk);
    do_txn("lw_after_rst", 1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h0123_4567, 1);

    do_txn("lw_misalign", 1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 0);
    do_txn("lw_refill",   1, 0, 2'b10, 0, 32'h108, 32'h0, 32'h7777_1111, 0);
    do_txn("rd_and_wr",   1, 1, 2'b10, 0, 32'h100, 32'h0, 32'h0, 0);
    do_txn("lh_odd",      1, 0, 2'b01, 0, 32'h101, 32'h0, 32'h0, 0);
    do_txn("lw_refill2",  1, 0, 2'b10, 0, 32'h10C, 32'h0, 32'h2468_ACE0, 0);
    do_txn("size_11",     1, 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 0);
    do_txn("lw_refill3",  1, 0, 2'b10, 0, 32'h110, 32'h0, 32'h1357_9BDF, 0);
    do_txn("lw_timeout",  1, 0, 2'b10, 0, 32'h120, 32'h0, 32'h0, -1);
    do_txn("sw_timeout",  0, 1, 2'b10, 0, 32'h124, 32'h1111_2222, 32'h0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
